mem_refill: RTL

Line-refill controller between the split L1 caches and main memory. It arbitrates between instruction-cache and data-cache misses and issues one line read per miss. It assembles two 32-bit memory beats into a 64-bit line, then pulses the matching fill strobe. The fill strobe drives the tag array and the data array of the selected cache together.

---
 rtl/mem_refill_pkg.sv | 21 ++
 rtl/mem_refill_if.sv | 22 ++
 rtl/mem_refill_arb.sv | 46 ++++
 rtl/mem_refill.sv | 94 +++++++++
 4 files changed

// File: rtl/mem_refill_pkg.sv
// Shared types and constants for the L1 line-refill controller.
// Used by mem_refill and refill_arb.
package mem_refill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BEAT0,
        BEAT1,
        FILL
    } state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } src_t;

    localparam int LINE_OFFSET_W  = 3;
    localparam int BEATS_PER_LINE = 2;

endpackage

// File: rtl/mem_refill_if.sv
// Memory read port of the refill controller.
// The controller is master; the memory is slave.
interface mem_refill_if #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [BEAT_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_refill_arb.sv
// I/D miss arbiter for the refill controller.
// REFILL_RR_EN selects round-robin; otherwise D has fixed priority.
module refill_arb
    import mem_refill_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_miss,
    input  logic d_miss,
    input  logic en,
    output src_t winner
);

`ifdef REFILL_RR_EN
    // ptr_q is the source that wins the next contended arbitration.
    src_t ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= SRC_D;
        end else if (en && i_miss && d_miss) begin
            ptr_q <= (ptr_q == SRC_D) ? SRC_I : SRC_D;
        end
    end

    always_comb begin
        winner = SRC_D;
        if (i_miss && d_miss) begin
            winner = ptr_q;
        end else if (i_miss) begin
            winner = SRC_I;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = clk ^ rst ^ en;

    always_comb begin
        winner = SRC_D;
        if (i_miss && !d_miss) begin
            winner = SRC_I;
        end
    end
`endif

endmodule

// File: rtl/mem_refill.sv
// Line-refill controller: arbitrates I/D misses, fetches two beats, pulses a fill strobe.
// Optional macro REFILL_RR_EN enables round-robin arbitration in refill_arb.
//
// state | meaning
// IDLE  | waiting for a miss; latches winner and line address
// REQ   | mem_req high until mem_gnt
// BEAT0 | waiting for low beat
// BEAT1 | waiting for high beat
// FILL  | one-cycle strobe to the selected cache if its miss is still pending
module mem_refill
    import mem_refill_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 32,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              i_fill,
    output logic              d_fill,
    output logic [LINE_W-1:0] line,
    output logic              busy,
    mem_refill_if.master      mem
);

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LINE_OFFSET_W) - 1);

    state_t            state_q, state_d;
    src_t              src_q, win;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [LINE_W-1:0] line_q;
    logic              busy_q;
    logic              start;

    assign start    = (state_q == IDLE) && (i_miss || d_miss);
    assign sel_addr = (win == SRC_I) ? i_addr : d_addr;

    refill_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_miss (i_miss),
        .d_miss (d_miss),
        .en     (start),
        .winner (win)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)          state_d = REQ;
            REQ:     if (mem.mem_gnt)    state_d = BEAT0;
            BEAT0:   if (mem.mem_rvalid) state_d = BEAT1;
            BEAT1:   if (mem.mem_rvalid) state_d = FILL;
            FILL:                        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= SRC_D;
            addr_q  <= '0;
            line_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (start) begin
                src_q  <= win;
                addr_q <= sel_addr & ~OFFSET_MASK;
            end
            if (state_q == BEAT0 && mem.mem_rvalid) begin
                line_q[BEAT_W-1:0] <= mem.mem_rdata;
            end
            if (state_q == BEAT1 && mem.mem_rvalid) begin
                line_q[LINE_W-1:BEAT_W] <= mem.mem_rdata;
            end
        end
    end

    // A miss that dropped before FILL means the request was abandoned: no strobe.
    assign i_fill       = (state_q == FILL) && (src_q == SRC_I) && i_miss;
    assign d_fill       = (state_q == FILL) && (src_q == SRC_D) && d_miss;
    assign line         = line_q;
    assign busy         = busy_q;
    assign mem.mem_req  = (state_q == REQ);
    assign mem.mem_addr = addr_q;

endmodule
